// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory access controller.
// Holds the FSM encoding, funct3 codes and store-lane helpers.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte enables for a store of the given size at byte offset off.
    function automatic logic [3:0] store_mask(
        input logic [2:0] funct3,
        input logic [1:0] off
    );
        logic [3:0] m;
        case (funct3[1:0])
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Replicate the store operand so every enabled lane carries it.
    function automatic logic [31:0] store_data(
        input logic [2:0]  funct3,
        input logic [31:0] wdata
    );
        logic [31:0] d;
        case (funct3[1:0])
            2'b00:   d = {4{wdata[7:0]}};
            2'b01:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic misaligned(
        input logic [2:0] funct3,
        input logic [1:0] off
    );
        logic m;
        case (funct3[1:0])
            2'b01:   m = off[0];
            2'b10:   m = (off != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Data-cache request/response channel.
// master = access controller, slave = cache.
interface dmem_if #(
    parameter int ADDR_W = 32
);
    logic              dc_req_valid;
    logic              dc_req_ready;
    logic [ADDR_W-1:0] dc_addr;
    logic [31:0]       dc_wdata;
    logic [3:0]        dc_wmask;
    logic              dc_resp_valid;
    logic [31:0]       dc_rdata;

    modport master (
        output dc_req_valid,
        output dc_addr,
        output dc_wdata,
        output dc_wmask,
        input  dc_req_ready,
        input  dc_resp_valid,
        input  dc_rdata
    );

    modport slave (
        input  dc_req_valid,
        input  dc_addr,
        input  dc_wdata,
        input  dc_wmask,
        output dc_req_ready,
        output dc_resp_valid,
        output dc_rdata
    );
endinterface

// File: rtl/dmem_load_extract.sv
// Load result alignment and sign/zero extension.
// Shifts the raw cache word down by the byte offset, then extends.
module load_extract
    import dmem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] ld_data
);

    logic [31:0] sh;

    assign sh = rdata >> {off, 3'b000};

    // Extend by access size; unused funct3 codes behave as LW.
    always_comb begin
        ld_data = sh;
        unique case (1'b1)
            (funct3 == F3_B):  ld_data = {{24{sh[7]}}, sh[7:0]};
            (funct3 == F3_H):  ld_data = {{16{sh[15]}}, sh[15:0]};
            (funct3 == F3_BU): ld_data = {24'd0, sh[7:0]};
            (funct3 == F3_HU): ld_data = {16'd0, sh[15:0]};
            default:           ld_data = sh;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage load/store sequencer into the data cache.
// Optional perf counters: define DMEM_PERF_EN.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_valid,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [2:0]        mem_funct3,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              pipe_hold,
    output logic              dmem_stall,
    output logic [DATA_W-1:0] ld_data,
    output logic              misalign,
    dmem_if.master            dc,
    output logic [31:0]       perf_loads,
    output logic [31:0]       perf_stores,
    output logic [31:0]       perf_stall_cyc
);

    state_t state, state_n;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] ld_q;
    logic [3:0]        mask_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic              load_q;

    logic              is_acc;
    logic              mis;
    logic              stall;
    logic              req;
    logic              mis_p;
    logic              lat;
    logic              take;
    logic [DATA_W-1:0] ext;

    assign is_acc = mem_valid & (mem_re | mem_we);
    assign mis    = misaligned(mem_funct3, mem_addr[1:0]);

    load_extract u_ext (
        .rdata   (dc.dc_rdata),
        .off     (off_q),
        .funct3  (f3_q),
        .ld_data (ext)
    );

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_n = state;
        stall   = 1'b0;
        req     = 1'b0;
        mis_p   = 1'b0;
        lat     = 1'b0;
        take    = 1'b0;
        case (state)
            IDLE: begin
                mis_p = is_acc & mis;
                if (is_acc & ~mis) begin
                    stall   = 1'b1;
                    lat     = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                req   = 1'b1;
                if (dc.dc_req_ready)
                    state_n = load_q ? WAIT : DONE;
            end
            WAIT: begin
                stall = 1'b1;
                if (dc.dc_resp_valid) begin
                    take    = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                if (!pipe_hold) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Request registers and the held load result.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            load_q  <= 1'b0;
            ld_q    <= '0;
        end else begin
            if (lat) begin
                addr_q  <= {mem_addr[ADDR_W-1:2], 2'b00};
                wdata_q <= store_data(mem_funct3, mem_wdata);
                mask_q  <= mem_we ?
                           store_mask(mem_funct3, mem_addr[1:0]) :
                           4'b0000;
                f3_q    <= mem_funct3;
                off_q   <= mem_addr[1:0];
                load_q  <= ~mem_we;
            end
            if (take) ld_q <= ext;
        end
    end

    assign dmem_stall      = stall & ~reset;
    assign misalign        = mis_p & ~reset;
    assign ld_data         = reset ? '0 : ld_q;
    assign dc.dc_req_valid = req & ~reset;
    assign dc.dc_addr      = reset ? '0 : addr_q;
    assign dc.dc_wdata     = reset ? '0 : wdata_q;
    assign dc.dc_wmask     = reset ? '0 : mask_q;

`ifdef DMEM_PERF_EN
    logic [31:0] n_ld;
    logic [31:0] n_st;
    logic [31:0] n_stl;
    logic        acc;

    assign acc = req & dc.dc_req_ready;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_ld  <= '0;
            n_st  <= '0;
            n_stl <= '0;
        end else begin
            if (acc & load_q)  n_ld  <= n_ld + 32'd1;
            if (acc & ~load_q) n_st  <= n_st + 32'd1;
            if (stall)         n_stl <= n_stl + 32'd1;
        end
    end

    assign perf_loads     = reset ? '0 : n_ld;
    assign perf_stores    = reset ? '0 : n_st;
    assign perf_stall_cyc = reset ? '0 : n_stl;
`else
    assign perf_loads     = '0;
    assign perf_stores    = '0;
    assign perf_stall_cyc = '0;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl.
// Covers loads, stores, backpressure, misalignment, reset mid-access.
module tb_dmem_access_ctrl;
    import dmem_pkg::*;

    logic        clk;
    logic        reset;
    logic        mem_valid;
    logic        mem_re;
    logic        mem_we;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        pipe_hold;
    logic        dmem_stall;
    logic [31:0] ld_data;
    logic        misalign;
    logic [31:0] perf_loads;
    logic [31:0] perf_stores;
    logic [31:0] perf_stall_cyc;

    int tests = 0;
    int fails = 0;
    int acc;

    dmem_if #(.ADDR_W(32)) dc ();

    dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_valid      (mem_valid),
        .mem_re         (mem_re),
        .mem_we         (mem_we),
        .mem_funct3     (mem_funct3),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .pipe_hold      (pipe_hold),
        .dmem_stall     (dmem_stall),
        .ld_data        (ld_data),
        .misalign       (misalign),
        .dc             (dc),
        .perf_loads     (perf_loads),
        .perf_stores    (perf_stores),
        .perf_stall_cyc (perf_stall_cyc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One access with ready always high and the response on the
    // first legal cycle; optionally holds in DONE for hold cycles.
    task automatic access(input string tag, input logic re,
                          input logic we, input logic [2:0] f3,
                          input logic [31:0] addr,
                          input logic [31:0] wd,
                          input logic [31:0] rd,
                          input int exp_stall,
                          input logic [31:0] exp_ld,
                          input logic [3:0] exp_mask,
                          input logic [31:0] exp_wd,
                          input int hold);
        int  stalls;
        int  nacc;
        bit  done;
        bit  pend;
        stalls = 0;
        nacc   = 0;
        done   = 0;
        mem_valid    = 1'b1;
        mem_re       = re;
        mem_we       = we;
        mem_funct3   = f3;
        mem_addr     = addr;
        mem_wdata    = wd;
        dc.dc_req_ready  = 1'b1;
        dc.dc_resp_valid = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            #1;
            if (!dmem_stall) begin
                done = 1;
            end else begin
                stalls++;
                pend = 0;
                if (dc.dc_req_valid) begin
                    nacc++;
                    chk({tag, " addr"}, dc.dc_addr, addr & ~32'h3);
                    chk({tag, " mask"}, {28'd0, dc.dc_wmask},
                        {28'd0, exp_mask});
                    if (we) chk({tag, " wdata"}, dc.dc_wdata, exp_wd);
                    pend = !we;
                end
                tick();
                dc.dc_resp_valid = pend;
                dc.dc_rdata      = rd;
            end
        end
        chk({tag, " done"}, {31'd0, done}, 32'd1);
        chk({tag, " stalls"}, stalls, exp_stall);
        chk({tag, " accepts"}, nacc, 1);
        if (!we) chk({tag, " ld_data"}, ld_data, exp_ld);
        for (int h = 0; h < hold; h++) begin
            pipe_hold = 1'b1;
            tick();
            dc.dc_rdata = 32'h5A5A5A5A;
            #1;
            chk({tag, " hold stall"}, {31'd0, dmem_stall}, 32'd0);
            chk({tag, " hold ld_data"}, ld_data, exp_ld);
        end
        pipe_hold = 1'b0;
        mem_valid = 1'b0;
        tick();
    endtask

    initial begin
        reset            = 1'b1;
        mem_valid        = 1'b1;
        mem_re           = 1'b1;
        mem_we           = 1'b0;
        mem_funct3       = F3_W;
        mem_addr         = 32'h100;
        mem_wdata        = 32'hFFFFFFFF;
        pipe_hold        = 1'b0;
        dc.dc_req_ready  = 1'b1;
        dc.dc_resp_valid = 1'b1;
        dc.dc_rdata      = 32'h11111111;

        tick();
        tick();
        #1;
        chk("rst stall", {31'd0, dmem_stall}, 32'd0);
        chk("rst misalign", {31'd0, misalign}, 32'd0);
        chk("rst req_valid", {31'd0, dc.dc_req_valid}, 32'd0);
        chk("rst ld_data", ld_data, 32'd0);
        chk("rst addr", dc.dc_addr, 32'd0);
        chk("rst wmask", {28'd0, dc.dc_wmask}, 32'd0);
        chk("rst perf", perf_loads | perf_stores | perf_stall_cyc, 32'd0);

        mem_valid        = 1'b0;
        dc.dc_resp_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        access("LW 100", 1, 0, F3_W, 32'h100, 0, 32'hDEADBEEF,
               3, 32'hDEADBEEF, 4'b0000, 0, 0);
        access("LB 103", 1, 0, F3_B, 32'h103, 0, 32'h80FF1234,
               3, 32'hFFFFFF80, 4'b0000, 0, 2);
        access("LBU 103", 1, 0, F3_BU, 32'h103, 0, 32'h80FF1234,
               3, 32'h00000080, 4'b0000, 0, 0);
        access("LH 102", 1, 0, F3_H, 32'h102, 0, 32'h80017FFF,
               3, 32'hFFFF8001, 4'b0000, 0, 0);
        access("LHU 100", 1, 0, F3_HU, 32'h100, 0, 32'h8001F00D,
               3, 32'h0000F00D, 4'b0000, 0, 0);
        access("LB 100", 1, 0, F3_B, 32'h100, 0, 32'h0000007F,
               3, 32'h0000007F, 4'b0000, 0, 0);
        access("L011 104", 1, 0, 3'b011, 32'h104, 0, 32'hCAFEF00D,
               3, 32'hCAFEF00D, 4'b0000, 0, 0);
        access("SH 102", 0, 1, F3_H, 32'h102, 32'h0000ABCD, 0,
               2, 0, 4'b1100, 32'hABCDABCD, 0);
        access("SB 101", 0, 1, F3_B, 32'h101, 32'h000000A5, 0,
               2, 0, 4'b0010, 32'hA5A5A5A5, 0);
        access("RW SW 108", 1, 1, F3_W, 32'h108, 32'h11223344, 0,
               2, 0, 4'b1111, 32'h11223344, 0);

        // Backpressure: ready low for five cycles.
        mem_valid       = 1'b1;
        mem_re          = 1'b0;
        mem_we          = 1'b1;
        mem_funct3      = F3_W;
        mem_addr        = 32'h200;
        mem_wdata       = 32'h12345678;
        dc.dc_req_ready = 1'b0;
        acc             = 0;
        #1;
        chk("bp idle stall", {31'd0, dmem_stall}, 32'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp req_valid", {31'd0, dc.dc_req_valid}, 32'd1);
            chk("bp addr", dc.dc_addr, 32'h200);
            chk("bp wdata", dc.dc_wdata, 32'h12345678);
            chk("bp stall", {31'd0, dmem_stall}, 32'd1);
            if (dc.dc_req_valid && dc.dc_req_ready) acc++;
            tick();
        end
        dc.dc_req_ready = 1'b1;
        #1;
        chk("bp final req", {31'd0, dc.dc_req_valid}, 32'd1);
        chk("bp final addr", dc.dc_addr, 32'h200);
        if (dc.dc_req_valid && dc.dc_req_ready) acc++;
        tick();
        mem_valid = 1'b0;
        #1;
        chk("bp done stall", {31'd0, dmem_stall}, 32'd0);
        chk("bp done req", {31'd0, dc.dc_req_valid}, 32'd0);
        chk("bp accepts", acc, 1);
        tick();

        // Misaligned word load.
        mem_valid  = 1'b1;
        mem_re     = 1'b1;
        mem_we     = 1'b0;
        mem_funct3 = F3_W;
        mem_addr   = 32'h102;
        #1;
        chk("mis LW pulse", {31'd0, misalign}, 32'd1);
        chk("mis LW stall", {31'd0, dmem_stall}, 32'd0);
        chk("mis LW req", {31'd0, dc.dc_req_valid}, 32'd0);
        tick();
        mem_valid = 1'b0;
        #1;
        chk("mis LW after", {31'd0, misalign}, 32'd0);
        chk("mis LW idle req", {31'd0, dc.dc_req_valid}, 32'd0);
        chk("mis LW idle stall", {31'd0, dmem_stall}, 32'd0);
        tick();

        // Misaligned halfword store.
        mem_valid  = 1'b1;
        mem_re     = 1'b0;
        mem_we     = 1'b1;
        mem_funct3 = F3_H;
        mem_addr   = 32'h101;
        #1;
        chk("mis SH pulse", {31'd0, misalign}, 32'd1);
        chk("mis SH stall", {31'd0, dmem_stall}, 32'd0);
        mem_valid = 1'b0;
        tick();
        #1;
        chk("mis SH req", {31'd0, dc.dc_req_valid}, 32'd0);
        tick();

        // Reset while waiting on a load response.
        mem_valid        = 1'b1;
        mem_re           = 1'b1;
        mem_we           = 1'b0;
        mem_funct3       = F3_W;
        mem_addr         = 32'h300;
        dc.dc_req_ready  = 1'b1;
        dc.dc_resp_valid = 1'b0;
        #1;
        chk("rw idle stall", {31'd0, dmem_stall}, 32'd1);
        tick();
        #1;
        chk("rw req", {31'd0, dc.dc_req_valid}, 32'd1);
        tick();
        #1;
        chk("rw wait stall", {31'd0, dmem_stall}, 32'd1);
        chk("rw wait req", {31'd0, dc.dc_req_valid}, 32'd0);
`ifdef DMEM_PERF_EN
        chk("perf loads", perf_loads, 32'd8);
        chk("perf stores", perf_stores, 32'd4);
        chk("perf stall", perf_stall_cyc, 32'd36);
`endif
        reset = 1'b1;
        #1;
        chk("rw rst stall", {31'd0, dmem_stall}, 32'd0);
        chk("rw rst req", {31'd0, dc.dc_req_valid}, 32'd0);
        chk("rw rst ld_data", ld_data, 32'd0);
        tick();
        reset            = 1'b0;
        mem_valid        = 1'b0;
        dc.dc_resp_valid = 1'b1;
        dc.dc_rdata      = 32'hFFFFFFFF;
        #1;
        chk("rw post stall", {31'd0, dmem_stall}, 32'd0);
        chk("rw post req", {31'd0, dc.dc_req_valid}, 32'd0);
        tick();
        dc.dc_resp_valid = 1'b0;
        #1;
        chk("rw post ld_data", ld_data, 32'd0);
        chk("rw post stall2", {31'd0, dmem_stall}, 32'd0);
        chk("rw post perf", perf_loads | perf_stores | perf_stall_cyc,
            32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
